mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Consumes the EX/MEM pipeline register outputs and performs the MEM stage of the 5-stage pipeline.
- Runs a req/ack handshake with a multi-cycle data memory and stalls the front of the pipeline while an access is outstanding.
- Registers the results into the MEM/WB boundary.
- Acts as the responder/consumer for the EX/MEM control and data fields.

Parameters:
- DATA_W, 32, width of data word and ALU result/address.
- TIMEOUT, 255, max wait cycles for mem_ack_i before forced completion (1..255).
- TMO_W, 8, width of the wait counter; must satisfy 2^TMO_W > TIMEOUT.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- writeBack_i  in  1  EX/MEM register-write enable.
- memtoReg_i  in  1  EX/MEM select memory data for writeback.
- memRead_i  in  1  EX/MEM load request.
- memWrite_i  in  1  EX/MEM store request.
- ALUresult_i  in  DATA_W  EX/MEM ALU result / memory byte address.
- memWriteData_i  in  DATA_W  EX/MEM store data.
- regDstAddr_i  in  5  EX/MEM destination register.
- mem_req_o  out  1  memory request, held high until ack.
- mem_we_o  out  1  1 = write, 0 = read; valid with mem_req_o.
- mem_addr_o  out  DATA_W  latched address.
- mem_wdata_o  out  DATA_W  latched store data.
- mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i=1.
- mem_ack_i  in  1  one-cycle completion pulse.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational).
- err_o  out  1  sticky timeout flag.
- writeBack_o  out  1  MEM/WB register-write enable.
- memtoReg_o  out  1  MEM/WB select.
- memReadData_o  out  DATA_W  MEM/WB load data.
- ALUresult_o  out  DATA_W  MEM/WB ALU result.
- regDstAddr_o  out  5  MEM/WB destination register.

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE, wait counter=0, err_o=0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o = 0.
  - All MEM/WB outputs = 0.
  - Overrides any in-flight access; a late mem_ack_i after reset is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no access (memRead_i=memWrite_i=0):
  - stall_o=0.
  - MEM/WB outputs load the inputs at the next edge (1-cycle latency).
  - memReadData_o=0.
- IDLE, access (memRead_i|memWrite_i):
  - stall_o=1 in the same cycle.
  - At the edge, latch address, write data, mem_we=memWrite_i, and control fields. Go to WAIT, counter=0.
  - MEM/WB loads a bubble (writeBack_o=0, memtoReg_o=0, others 0).
- Read and write both asserted: write wins (mem_we_o=1). memReadData_o=0 on completion, and writeBack/memtoReg pass through unchanged.
- WAIT:
  - mem_req_o=1; addr, wdata, and we are stable. stall_o=1. MEM/WB holds a bubble each cycle.
  - Counter increments every cycle without ack.
  - On mem_ack_i=1: capture mem_rdata_i (reads only; writes capture 0), drop mem_req_o at the edge, go to DONE.
  - On counter==TIMEOUT without ack: set err_o, capture 0, drop mem_req_o, go to DONE.
  - If ack and timeout coincide, ack wins and err_o is not set.
- DONE:
  - stall_o=0. Inputs are ignored as a new access; EX/MEM still holds the same instruction.
  - At the edge, MEM/WB loads the latched control, captured read data, latched ALU result, and regDst. Go to IDLE.
  - Each access therefore costs (ack wait + 2) cycles minimum: 1 IDLE detect cycle, >=1 WAIT cycle, 1 DONE cycle.
- mem_ack_i outside WAIT is ignored.
- Address is passed unmodified; the low 2 bits are not checked.
- err_o clears only on reset.

Decomposition:
- Shared pipeline package:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
  - REG_ADDR_W=5 and DATA_W default.
  - A MEM/WB bubble constant.
- One natural sub-module, mem_wait_timer: counter with clear/enable/expire, parameterised by TIMEOUT and TMO_W.
- The FSM and MEM/WB register stay in mem_access_stage.

Test Plan:
- Reset, then non-memory op (writeBack_i=1, ALUresult_i=0x0000_0010, regDst=5):
  - Next edge: writeBack_o=1, ALUresult_o=0x10, regDstAddr_o=5.
  - stall_o=0 throughout, mem_req_o never high.
- Load addr 0x40, memtoReg=1, regDst=8, ack after 3 cycles with rdata 0xDEAD_BEEF:
  - stall_o high 4 cycles (IDLE+3 WAIT).
  - Bubbles on MEM/WB during the stall.
  - After DONE: memReadData_o=0xDEADBEEF, regDstAddr_o=8, writeBack_o=1.
- Store addr 0x80, data 0x1234_5678, ack after 1 cycle:
  - mem_we_o=1, mem_addr_o=0x80, mem_wdata_o=0x12345678 stable while mem_req_o=1.
  - writeBack_o=0, and no re-issue in DONE.
- No ack, TIMEOUT=4:
  - mem_req_o high exactly 5 WAIT cycles.
  - err_o=1 sticky, memReadData_o=0, pipeline resumes.
- rst_i asserted during WAIT, then a stray mem_ack_i:
  - All outputs 0 next edge, state IDLE, err_o=0, and the ack is ignored.
- memRead_i=memWrite_i=1 at addr 0x20:
  - mem_we_o=1 and memReadData_o=0 on completion.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Contents: FSM state encoding, register-address width, default data width,
// and the control-field bubble loaded into MEM/WB while the stage is busy.
package mem_access_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef struct packed {
        logic write_back;
        logic memto_reg;
    } memwb_ctrl_t;

    // Control half of a MEM/WB bubble; data fields of a bubble are all zero.
    localparam memwb_ctrl_t MEMWB_CTRL_BUBBLE = '{write_back: 1'b0, memto_reg: 1'b0};

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory access.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   clr_i         force count to zero (has priority over en_i)
//   en_i          increment count
//   expired_o     count has reached TIMEOUT
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TMO_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TMO_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of a 5-stage pipeline.
// Takes the EX/MEM register fields, runs a req/ack handshake with a multi-cycle
// data memory, stalls the front of the pipeline while an access is in flight,
// and registers the result into MEM/WB.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   writeBack_i .. regDstAddr_i  EX/MEM fields
//   mem_req_o/we_o/addr_o/wdata_o, mem_rdata_i, mem_ack_i  data-memory port
//   stall_o                      combinational front-of-pipe freeze
//   err_o                        sticky access timeout flag
//   writeBack_o .. regDstAddr_o  MEM/WB fields
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TMO_W   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  writeBack_i,
    input  logic                  memtoReg_i,
    input  logic                  memRead_i,
    input  logic                  memWrite_i,
    input  logic [DATA_W-1:0]     ALUresult_i,
    input  logic [DATA_W-1:0]     memWriteData_i,
    input  logic [REG_ADDR_W-1:0] regDstAddr_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic                  stall_o,
    output logic                  err_o,
    output logic                  writeBack_o,
    output logic                  memtoReg_o,
    output logic [DATA_W-1:0]     memReadData_o,
    output logic [DATA_W-1:0]     ALUresult_o,
    output logic [REG_ADDR_W-1:0] regDstAddr_o
);

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    memwb_ctrl_t           ctrl_q, ctrl_d;       // latched EX/MEM control
    logic [REG_ADDR_W-1:0] dst_q, dst_d;         // latched destination register
    logic [DATA_W-1:0]     cap_q, cap_d;         // captured read data
    logic                  err_q, err_d;

    memwb_ctrl_t           wb_ctrl_q, wb_ctrl_d;
    logic [DATA_W-1:0]     wb_rdata_q, wb_rdata_d;
    logic [DATA_W-1:0]     wb_alu_q, wb_alu_d;
    logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;

    logic access;
    logic tmr_clr, tmr_en, tmr_expired;

    assign access = memRead_i | memWrite_i;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ctrl_d     = ctrl_q;
        dst_d      = dst_q;
        cap_d      = cap_q;
        err_d      = err_q;
        wb_ctrl_d  = MEMWB_CTRL_BUBBLE;
        wb_rdata_d = '0;
        wb_alu_d   = '0;
        wb_dst_d   = '0;
        tmr_clr    = 1'b1;
        tmr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (access) begin
                    state_d = StWait;
                    req_d   = 1'b1;
                    we_d    = memWrite_i;  // write wins when both are set
                    addr_d  = ALUresult_i;
                    wdata_d = memWriteData_i;
                    ctrl_d  = '{write_back: writeBack_i, memto_reg: memtoReg_i};
                    dst_d   = regDstAddr_i;
                end else begin
                    wb_ctrl_d = '{write_back: writeBack_i, memto_reg: memtoReg_i};
                    wb_alu_d  = ALUresult_i;
                    wb_dst_d  = regDstAddr_i;
                end
            end
            StWait: begin
                tmr_clr = 1'b0;
                if (mem_ack_i) begin
                    // Ack beats a coincident timeout.
                    cap_d   = we_q ? '0 : mem_rdata_i;
                    req_d   = 1'b0;
                    state_d = StDone;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    cap_d   = '0;
                    req_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StDone: begin
                // EX/MEM still holds the finished instruction; do not re-issue it.
                wb_ctrl_d  = ctrl_q;
                wb_rdata_d = cap_q;
                wb_alu_d   = addr_q;
                wb_dst_d   = dst_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ctrl_q     <= MEMWB_CTRL_BUBBLE;
            dst_q      <= '0;
            cap_q      <= '0;
            err_q      <= 1'b0;
            wb_ctrl_q  <= MEMWB_CTRL_BUBBLE;
            wb_rdata_q <= '0;
            wb_alu_q   <= '0;
            wb_dst_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ctrl_q     <= ctrl_d;
            dst_q      <= dst_d;
            cap_q      <= cap_d;
            err_q      <= err_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_rdata_q <= wb_rdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_dst_q   <= wb_dst_d;
        end
    end

    assign stall_o       = (state_q == StWait) | ((state_q == StIdle) & access);
    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign err_o         = err_q;
    assign writeBack_o   = wb_ctrl_q.write_back;
    assign memtoReg_o    = wb_ctrl_q.memto_reg;
    assign memReadData_o = wb_rdata_q;
    assign ALUresult_o   = wb_alu_q;
    assign regDstAddr_o  = wb_dst_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a per-cycle scoreboard.
// The stimulus process drives one cycle of inputs and pushes the hand-computed
// outputs expected in that cycle; the monitor pops and compares on the falling edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst, wb_i, m2r_i, rd_i, wr_i, ack;
    logic [31:0] alu_i, wd_i, rdata_i;
    logic [4:0]  dst_i;

    logic        req, we, stall, err, wb_o, m2r_o;
    logic [31:0] addr, wdata, rdata_o, alu_o;
    logic [4:0]  dst_o;

    int tot = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W  (32),
        .TIMEOUT (4),
        .TMO_W   (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .writeBack_i    (wb_i),
        .memtoReg_i     (m2r_i),
        .memRead_i      (rd_i),
        .memWrite_i     (wr_i),
        .ALUresult_i    (alu_i),
        .memWriteData_i (wd_i),
        .regDstAddr_i   (dst_i),
        .mem_req_o      (req),
        .mem_we_o       (we),
        .mem_addr_o     (addr),
        .mem_wdata_o    (wdata),
        .mem_rdata_i    (rdata_i),
        .mem_ack_i      (ack),
        .stall_o        (stall),
        .err_o          (err),
        .writeBack_o    (wb_o),
        .memtoReg_o     (m2r_o),
        .memReadData_o  (rdata_o),
        .ALUresult_o    (alu_o),
        .regDstAddr_o   (dst_o)
    );

    typedef struct {
        logic        rst, wb, m2r, rd, wr;
        logic [31:0] alu, wd;
        logic [4:0]  dst;
        logic [31:0] rdata;
        logic        ack;
    } in_t;

    typedef struct {
        logic        stall, req, we;
        logic [31:0] addr, wdata;
        logic        err, wb, m2r;
        logic [31:0] rdata, alu;
        logic [4:0]  dst;
    } exp_t;

    exp_t exp_q[$];

    function automatic in_t mk_in(logic r, logic w, logic m, logic rd, logic wr,
                                  logic [31:0] a, logic [31:0] d, logic [4:0] ds,
                                  logic [31:0] rdat, logic ak);
        in_t i;
        i.rst = r; i.wb = w; i.m2r = m; i.rd = rd; i.wr = wr;
        i.alu = a; i.wd = d; i.dst = ds; i.rdata = rdat; i.ack = ak;
        return i;
    endfunction

    function automatic exp_t mk_ex(logic s, logic rq, logic w, logic [31:0] a,
                                   logic [31:0] d, logic e, logic b, logic m,
                                   logic [31:0] rdat, logic [31:0] al, logic [4:0] ds);
        exp_t x;
        x.stall = s; x.req = rq; x.we = w; x.addr = a; x.wdata = d; x.err = e;
        x.wb = b; x.m2r = m; x.rdata = rdat; x.alu = al; x.dst = ds;
        return x;
    endfunction

    // Apply one cycle of inputs, record what the outputs must be this cycle.
    task automatic drive(input in_t i, input exp_t e);
        rst = i.rst; wb_i = i.wb; m2r_i = i.m2r; rd_i = i.rd; wr_i = i.wr;
        alu_i = i.alu; wd_i = i.wd; dst_i = i.dst; rdata_i = i.rdata; ack = i.ack;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int cyc, input string name, input logic [31:0] act,
                       input logic [31:0] want);
        tot++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, want);
        end
    endtask

    int mon_cyc = 0;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(mon_cyc, "stall_o",       {31'd0, stall}, {31'd0, e.stall});
            chk(mon_cyc, "mem_req_o",     {31'd0, req},   {31'd0, e.req});
            chk(mon_cyc, "mem_we_o",      {31'd0, we},    {31'd0, e.we});
            chk(mon_cyc, "mem_addr_o",    addr,           e.addr);
            chk(mon_cyc, "mem_wdata_o",   wdata,          e.wdata);
            chk(mon_cyc, "err_o",         {31'd0, err},   {31'd0, e.err});
            chk(mon_cyc, "writeBack_o",   {31'd0, wb_o},  {31'd0, e.wb});
            chk(mon_cyc, "memtoReg_o",    {31'd0, m2r_o}, {31'd0, e.m2r});
            chk(mon_cyc, "memReadData_o", rdata_o,        e.rdata);
            chk(mon_cyc, "ALUresult_o",   alu_o,          e.alu);
            chk(mon_cyc, "regDstAddr_o",  {27'd0, dst_o}, {27'd0, e.dst});
            mon_cyc++;
        end
    end

    initial begin
        in_t rs, z, nm, ld, lda, st, sta, lt, nm2, lr, lrr, stray, rw, rwa;
        exp_t zero;
        int guard;
        //          rst wb m2r rd wr alu          wdata         dst rdata         ack
        rs    = mk_in(1, 0, 0, 0, 0, 32'h0,       32'h0,        0, 32'h0,         0);
        z     = mk_in(0, 0, 0, 0, 0, 32'h0,       32'h0,        0, 32'h0,         0);
        nm    = mk_in(0, 1, 0, 0, 0, 32'h10,      32'h0,        5, 32'h0,         0);
        ld    = mk_in(0, 1, 1, 1, 0, 32'h40,      32'h0,        8, 32'h0,         0);
        lda   = mk_in(0, 1, 1, 1, 0, 32'h40,      32'h0,        8, 32'hDEADBEEF,  1);
        st    = mk_in(0, 0, 0, 0, 1, 32'h80,      32'h12345678, 0, 32'h0,         0);
        sta   = mk_in(0, 0, 0, 0, 1, 32'h80,      32'h12345678, 0, 32'hFFFFFFFF,  1);
        lt    = mk_in(0, 1, 1, 1, 0, 32'h44,      32'h0,        3, 32'h0,         0);
        nm2   = mk_in(0, 1, 0, 0, 0, 32'h99,      32'h0,        7, 32'h0,         0);
        lr    = mk_in(0, 1, 1, 1, 0, 32'h50,      32'h0,        9, 32'h0,         0);
        lrr   = mk_in(1, 1, 1, 1, 0, 32'h50,      32'h0,        9, 32'h0,         0);
        stray = mk_in(0, 0, 0, 0, 0, 32'h0,       32'h0,        0, 32'hCAFEF00D,  1);
        rw    = mk_in(0, 1, 1, 1, 1, 32'h20,      32'hA5A5A5A5, 4, 32'h0,         0);
        rwa   = mk_in(0, 1, 1, 1, 1, 32'h20,      32'hA5A5A5A5, 4, 32'h11111111,  1);
        zero  = mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1; wb_i = 0; m2r_i = 0; rd_i = 0; wr_i = 0;
        alu_i = '0; wd_i = '0; dst_i = '0; rdata_i = '0; ack = 0;
        @(posedge clk);
        #1;

        //             stall req we addr    wdata         err wb m2r rdata        alu     dst
        // Reset and a non-memory op
        drive(rs,  zero);
        drive(nm,  zero);
        drive(z,   mk_ex(0, 0, 0, 32'h0,  32'h0,        0, 1, 0, 32'h0,        32'h10, 5));
        // Load 0x40, ack in third WAIT cycle
        drive(ld,  mk_ex(1, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,        32'h0,  0));
        drive(ld,  mk_ex(1, 1, 0, 32'h40, 32'h0,        0, 0, 0, 32'h0,        32'h0,  0));
        drive(ld,  mk_ex(1, 1, 0, 32'h40, 32'h0,        0, 0, 0, 32'h0,        32'h0,  0));
        drive(lda, mk_ex(1, 1, 0, 32'h40, 32'h0,        0, 0, 0, 32'h0,        32'h0,  0));
        drive(ld,  mk_ex(0, 0, 0, 32'h40, 32'h0,        0, 0, 0, 32'h0,        32'h0,  0));
        drive(z,   mk_ex(0, 0, 0, 32'h40, 32'h0,        0, 1, 1, 32'hDEADBEEF, 32'h40, 8));
        // Store 0x80, ack in first WAIT cycle; read data must be dropped
        drive(st,  mk_ex(1, 0, 0, 32'h40, 32'h0,        0, 0, 0, 32'h0,        32'h0,  0));
        drive(sta, mk_ex(1, 1, 1, 32'h80, 32'h12345678, 0, 0, 0, 32'h0,        32'h0,  0));
        drive(st,  mk_ex(0, 0, 1, 32'h80, 32'h12345678, 0, 0, 0, 32'h0,        32'h0,  0));
        drive(z,   mk_ex(0, 0, 1, 32'h80, 32'h12345678, 0, 0, 0, 32'h0,        32'h80, 0));
        // Load with no ack: five WAIT cycles then timeout
        drive(lt,  mk_ex(1, 0, 1, 32'h80, 32'h12345678, 0, 0, 0, 32'h0,        32'h0,  0));
        for (int k = 0; k < 5; k++) begin
            drive(lt, mk_ex(1, 1, 0, 32'h44, 32'h0,     0, 0, 0, 32'h0,        32'h0,  0));
        end
        drive(lt,  mk_ex(0, 0, 0, 32'h44, 32'h0,        1, 0, 0, 32'h0,        32'h0,  0));
        drive(z,   mk_ex(0, 0, 0, 32'h44, 32'h0,        1, 1, 1, 32'h0,        32'h44, 3));
        drive(nm2, mk_ex(0, 0, 0, 32'h44, 32'h0,        1, 0, 0, 32'h0,        32'h0,  0));
        drive(z,   mk_ex(0, 0, 0, 32'h44, 32'h0,        1, 1, 0, 32'h0,        32'h99, 7));
        // Reset during WAIT, then a stray ack
        drive(lr,  mk_ex(1, 0, 0, 32'h44, 32'h0,        1, 0, 0, 32'h0,        32'h0,  0));
        drive(lr,  mk_ex(1, 1, 0, 32'h50, 32'h0,        1, 0, 0, 32'h0,        32'h0,  0));
        drive(lrr, mk_ex(1, 1, 0, 32'h50, 32'h0,        1, 0, 0, 32'h0,        32'h0,  0));
        drive(stray, zero);
        drive(z,   zero);
        // Read and write together: write wins, no read data
        drive(rw,  mk_ex(1, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,        32'h0,  0));
        drive(rwa, mk_ex(1, 1, 1, 32'h20, 32'hA5A5A5A5, 0, 0, 0, 32'h0,        32'h0,  0));
        drive(rw,  mk_ex(0, 0, 1, 32'h20, 32'hA5A5A5A5, 0, 0, 0, 32'h0,        32'h0,  0));
        drive(z,   mk_ex(0, 0, 1, 32'h20, 32'hA5A5A5A5, 0, 1, 1, 32'h0,        32'h20, 4));
        drive(z,   mk_ex(0, 0, 1, 32'h20, 32'hA5A5A5A5, 0, 0, 0, 32'h0,        32'h0,  0));

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        tot++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
